// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display scanner.
package disp_pkg;

  localparam int         MAX_DIGITS = 8;
  localparam logic [7:0] DIGIT_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Active-low strobe pattern selecting a single digit of the 8-digit board display
  function automatic logic [7:0] onehot_low(input logic [2:0] index);
    return ~(8'b0000_0001 << index);
  endfunction

endpackage

// File: rtl/hex2seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex2seg (
  input  logic [3:0] number,
  output logic [6:0] pattern
);

  // Pure lookup from nibble to segment pattern
  always_comb begin
    pattern = 7'h7F;
    case (number)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      4'hF: pattern = 7'h0E;
      default: pattern = 7'h7F;
    endcase
  end

endmodule

// File: rtl/disp_scan_n.sv
// Time-multiplexed scanner for up to 8 common-anode 7-segment digits with
// per-digit decimal points, 16-level PWM brightness, a dark anti-ghost phase
// at the start of each slot and frame-coherent capture of the displayed value.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module disp_scan_n
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_LOG2  = 10
) (
  input  logic                    clock5,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] dispVal,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [3:0]              brightness,
  output logic [7:0]              digit,
  output logic [7:0]              segment,
  output logic                    frame_start
);

  localparam logic [TICK_LOG2-1:0] PRESCALE_ONE = 1;
  localparam logic [2:0]           LAST_INDEX   = 3'(NUM_DIGITS - 1);

  logic [TICK_LOG2-1:0]    prescaler;
  logic [2:0]              index;
  logic [4*MAX_DIGITS-1:0] cap_val;
  logic [MAX_DIGITS-1:0]   cap_dp;
  logic [4*MAX_DIGITS-1:0] val_ext;
  logic [MAX_DIGITS-1:0]   dp_ext;
  logic                    tick;
  logic                    wrap;
  logic [3:0]              phase;
  logic                    strobe_on;
  logic [3:0]              nibble;
  logic [6:0]              hex_pat;
  logic                    blank;
  logic [7:0]              digit_next;
  logic [7:0]              segment_next;

  assign tick      = &prescaler;
  assign wrap      = tick && (index == LAST_INDEX);
  assign phase     = prescaler[TICK_LOG2-1 -: 4];
  assign strobe_on = (phase != 4'd0) && (phase <= brightness);
  assign nibble    = cap_val[{index, 2'b00} +: 4];

  // Zero-extend the inputs to the full 8-digit width so digit indexing needs no width games
  always_comb begin
    val_ext = '0;
    val_ext[4*NUM_DIGITS-1:0] = dispVal;
    dp_ext = '0;
    dp_ext[NUM_DIGITS-1:0] = dp;
  end

  // Free-running slot prescaler; its all-ones value is the slot tick
  always_ff @(posedge clock5 or negedge reset) begin
    if (!reset) prescaler <= '0;
    else        prescaler <= prescaler + PRESCALE_ONE;
  end

  // Digit index steps once per tick and wraps after the last used digit
  always_ff @(posedge clock5 or negedge reset) begin
    if (!reset)    index <= 3'd0;
    else if (tick) index <= wrap ? 3'd0 : index + 3'd1;
  end

  // Latch a whole frame's worth of digits at the wrap so a frame never tears
  always_ff @(posedge clock5 or negedge reset) begin
    if (!reset) begin
      cap_val <= '0;
      cap_dp  <= '0;
    end else if (wrap) begin
      cap_val <= val_ext;
      cap_dp  <= dp_ext;
    end
  end

  hex2seg u_hex2seg (
    .number  (nibble),
    .pattern (hex_pat)
  );

`ifdef DISP_LZB_EN
  logic [MAX_DIGITS-1:0] zero_from;

  // zero_from[k] is set when digit k and every digit above it are zero
  always_comb begin
    logic run;
    run = 1'b1;
    zero_from = '0;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      run = run && (cap_val[4*k +: 4] == 4'h0);
      zero_from[k] = run;
    end
  end

  assign blank = (index != 3'd0) && zero_from[index];
`else
  assign blank = 1'b0;
`endif

  // PWM compare and segment selection; everything dark outside the on-window
  always_comb begin
    digit_next   = DIGIT_OFF;
    segment_next = {SEG_OFF, 1'b1};
    if (strobe_on) begin
      digit_next   = onehot_low(index);
      segment_next = {(blank ? SEG_OFF : hex_pat), ~cap_dp[index]};
    end
  end

  // Register the pin drive so outputs are glitch-free and lag the scan state by one cycle
  always_ff @(posedge clock5 or negedge reset) begin
    if (!reset) begin
      digit       <= DIGIT_OFF;
      segment     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      digit       <= digit_next;
      segment     <= segment_next;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_disp_scan_n.sv
// Scoreboard bench for disp_scan_n: three instances (4 digits / 1 digit with
// 16-cycle slots, 8 digits with 32-cycle slots) share stimulus. A reference
// model derives every cycle's pin drive from the edge count since reset.
module tb_disp_scan_n;

  localparam int NS [3] = '{4, 1, 8};
  localparam int TS [3] = '{4, 4, 5};
  localparam logic [50:0] RESET_VEC = {3{17'h0FFFF}};

  logic        clock5     = 1'b0;
  logic        reset      = 1'b1;
  logic [31:0] disp_all   = '0;
  logic [7:0]  dp_all     = '0;
  logic [3:0]  brightness = 4'hF;

  logic [7:0] dig_a, seg_a, dig_b, seg_b, dig_c, seg_c;
  logic       fs_a, fs_b, fs_c;
  logic [50:0] act_all;

  int checks = 0;
  int errors = 0;
  logic [50:0] expq [$];

  assign act_all = {fs_a, dig_a, seg_a, fs_b, dig_b, seg_b, fs_c, dig_c, seg_c};

  always #5 clock5 = ~clock5;

  disp_scan_n #(.NUM_DIGITS(4), .TICK_LOG2(4)) dut_a (
    .clock5(clock5), .reset(reset), .dispVal(disp_all[15:0]), .dp(dp_all[3:0]),
    .brightness(brightness), .digit(dig_a), .segment(seg_a), .frame_start(fs_a));

  disp_scan_n #(.NUM_DIGITS(1), .TICK_LOG2(4)) dut_b (
    .clock5(clock5), .reset(reset), .dispVal(disp_all[3:0]), .dp(dp_all[0:0]),
    .brightness(brightness), .digit(dig_b), .segment(seg_b), .frame_start(fs_b));

  disp_scan_n #(.NUM_DIGITS(8), .TICK_LOG2(5)) dut_c (
    .clock5(clock5), .reset(reset), .dispVal(disp_all), .dp(dp_all),
    .brightness(brightness), .digit(dig_c), .segment(seg_c), .frame_start(fs_c));

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  // Expected {frame_start, digit, segment} seen after rising edge e since reset release
  function automatic logic [16:0] model_out(input int n, input int t, input int e,
                                            input logic [31:0] cv, input logic [7:0] cd,
                                            input logic [3:0] br);
    int slot, k, p, idx, ph;
    logic fs;
    logic [7:0] dig, seg;
    logic [3:0] nib;
    logic [31:0] upper;
    slot = 1 << t;
    k    = e - 1;
    p    = k % slot;
    idx  = (k / slot) % n;
    ph   = p >> (t - 4);
    fs   = ((e % (slot * n)) == 0);
    dig  = 8'hFF;
    seg  = 8'hFF;
    if (ph != 0 && ph <= int'(br)) begin
      dig[idx] = 1'b0;
      nib = cv[4*idx +: 4];
      seg = {hexseg(nib), ~cd[idx]};
      upper = cv >> (4 * idx);
`ifdef DISP_LZB_EN
      if (idx > 0 && upper == 32'd0) seg[7:1] = 7'h7F;
`endif
    end
    return {fs, dig, seg};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model: on each edge push the expected pins, then capture at frame wraps
  initial begin
    int e;
    logic [31:0] cv [3];
    logic [7:0]  cd [3];
    logic [16:0] ex [3];
    logic [31:0] vm;
    logic [7:0]  dm;
    e = 0;
    for (int i = 0; i < 3; i++) begin cv[i] = '0; cd[i] = '0; end
    forever begin
      @(posedge clock5 or negedge reset);
      if (!reset) begin
        e = 0;
        for (int i = 0; i < 3; i++) begin cv[i] = '0; cd[i] = '0; end
        expq.delete();
      end else begin
        e++;
        for (int i = 0; i < 3; i++) ex[i] = model_out(NS[i], TS[i], e, cv[i], cd[i], brightness);
        expq.push_back({ex[0], ex[1], ex[2]});
        for (int i = 0; i < 3; i++) begin
          if ((e % ((1 << TS[i]) * NS[i])) == 0) begin
            vm = 32'hFFFF_FFFF >> (32 - 4 * NS[i]);
            dm = 8'hFF >> (8 - NS[i]);
            cv[i] = disp_all & vm;
            cd[i] = dp_all & dm;
          end
        end
      end
    end
  end

  // Monitor: compare the registered outputs away from the active edge
  initial begin
    logic [50:0] exp_v;
    forever begin
      @(negedge clock5);
      if (reset && expq.size() > 0) begin
        exp_v = expq.pop_front();
        checkOutput("scan", {13'd0, act_all}, {13'd0, exp_v});
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] val, input logic [7:0] dpv,
                               input logic [3:0] br, input int cycles);
    @(negedge clock5);
    disp_all   = val;
    dp_all     = dpv;
    brightness = br;
    repeat (cycles) @(negedge clock5);
  endtask

  task automatic countWindow(output int low_a, output int low_b, output int low_c, output int fsb);
    low_a = 0; low_b = 0; low_c = 0; fsb = 0;
    repeat (64) begin
      @(negedge clock5);
      if (dig_a != 8'hFF) low_a++;
      if (dig_b != 8'hFF) low_b++;
      if (dig_c != 8'hFF) low_c++;
      if (fs_b) fsb++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int la, lb, lc, fb;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock5);
    #1 checkOutput("reset_por", {13'd0, act_all}, {13'd0, RESET_VEC});
    @(negedge clock5);
    #2 reset = 1'b1;

    applyStimulus(32'h8765_1234, 8'h00, 4'd15, 120);

    @(negedge clock5);
    #2 reset = 1'b0;
    #1 checkOutput("reset_mid", {13'd0, act_all}, {13'd0, RESET_VEC});
    repeat (2) @(negedge clock5);
    #2 reset = 1'b1;

    applyStimulus(32'h8765_1234, 8'h00, 4'd15, 100);
    applyStimulus(32'h4321_ABCD, 8'h00, 4'd15, 200);

    countWindow(la, lb, lc, fb);
    checkOutput("on15_a", 64'(la), 64'd60);
    checkOutput("on15_c", 64'(lc), 64'd60);

    applyStimulus(32'h4321_ABCD, 8'h00, 4'd0, 1);
    countWindow(la, lb, lc, fb);
    checkOutput("dark_a", 64'(la), 64'd0);
    checkOutput("dark_b", 64'(lb), 64'd0);
    checkOutput("dark_c", 64'(lc), 64'd0);

    applyStimulus(32'h4321_ABCD, 8'h00, 4'd3, 1);
    countWindow(la, lb, lc, fb);
    checkOutput("on3_a", 64'(la), 64'd12);
    checkOutput("on3_b", 64'(lb), 64'd12);
    checkOutput("on3_c", 64'(lc), 64'd12);
    checkOutput("fs_b_rate", 64'(fb), 64'd4);

    applyStimulus(32'h0F0F_5A5A, 8'hA5, 4'd15, 300);
    applyStimulus(32'h0000_0040, 8'h00, 4'd15, 600);

    for (int i = 0; i < 60; i++)
      applyStimulus($urandom, 8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(5, 40));

    repeat (2) @(negedge clock5);
    checkOutput("queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
